// File: rtl/kyber_add_pkg.sv
// Shared constants, enums and the small-coefficient decoder for the Kyber encapsulation add stage.
package kyber_add_pkg;

  localparam int KYBER_N       = 256;
  localparam int KYBER_Q       = 3329;
  localparam int KYBER_R_WIDTH = 12;
  localparam int SPOLY_W       = 3;

  typedef enum logic [1:0] {
    JOB_U0 = 2'd0,
    JOB_U1 = 2'd1,
    JOB_U2 = 2'd2,
    JOB_V  = 2'd3
  } job_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  // Negative small values are mapped to their mod-q representatives so the lane only ever adds.
  function automatic logic [KYBER_R_WIDTH-1:0] dec_small(input logic [SPOLY_W-1:0] code);
    logic [KYBER_R_WIDTH-1:0] val;
    case (code)
      3'b001:  val = KYBER_R_WIDTH'(1);
      3'b010:  val = KYBER_R_WIDTH'(2);
      3'b111:  val = KYBER_R_WIDTH'(KYBER_Q - 1);
      3'b110:  val = KYBER_R_WIDTH'(KYBER_Q - 2);
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/add_lane_modq.sv
// One coefficient lane: a + dec(e) + (optional) m, fully reduced into [0,Q).
module add_lane_modq
  import kyber_add_pkg::*;
#(
  parameter int Q = KYBER_Q
)(
  input  logic [KYBER_R_WIDTH-1:0] a,
  input  logic [SPOLY_W-1:0]       e,
  input  logic [KYBER_R_WIDTH-1:0] m,
  input  logic                     use_m,
  output logic [KYBER_R_WIDTH-1:0] r
);

  localparam int SW = KYBER_R_WIDTH + 2;
  localparam logic [SW-1:0] QW = SW'(Q);

  logic [SW-1:0] sum;
  logic [SW-1:0] red1;
  logic [SW-1:0] red2;

  // Three operands each below Q sum to less than 3Q, so two conditional subtractions suffice.
  always_comb begin
    sum  = SW'(a) + SW'(dec_small(e)) + (use_m ? SW'(m) : {SW{1'b0}});
    red1 = (sum >= QW) ? (sum - QW) : sum;
    red2 = (red1 >= QW) ? (red1 - QW) : red1;
    r    = KYBER_R_WIDTH'(red2);
  end

endmodule

// File: rtl/add_sched.sv
// Beat-serial scheduler for the Kyber encapsulation add stage: streams u[0..2] then v through a 2-entry output FIFO.
// Defining ADD_SCHED_DEBUG_EN adds the debug_state and stall_cnt observation ports.
module add_sched
  import kyber_add_pkg::*;
#(
  parameter int  LANES = 16,
  parameter int  N     = KYBER_N,
  parameter int  Q     = KYBER_Q,
  parameter int  OUT_D = 2,
  localparam int IDX_W = $clog2(N / LANES),
  localparam int DW    = LANES * KYBER_R_WIDTH,
  localparam int EW    = LANES * SPOLY_W
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [1:0]       rd_job,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [DW-1:0]    rd_a,
  input  logic [EW-1:0]    rd_e,
  input  logic [DW-1:0]    rd_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_job,
  output logic [IDX_W-1:0] out_idx,
  output logic [DW-1:0]    out_data
`ifdef ADD_SCHED_DEBUG_EN
  ,
  output logic [2:0]       debug_state,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int BW = 2 + IDX_W + DW;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N / LANES - 1);

  state_e           state;
  logic             inflight;
  logic [1:0]       job_q;
  logic [IDX_W-1:0] idx_q;
  logic             use_m;
  logic [DW-1:0]    lane_sum;

  logic [BW-1:0]    fifo_mem [OUT_D];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_count;
  logic             push;
  logic             pop;
  logic [2:0]       occupancy;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};

  // Credit check counts the beat being read this cycle so the FIFO can never be pushed while full.
  assign rd_en = (state == ST_ISSUE) && ((int'(occupancy) - int'(pop)) < OUT_D);

  assign {out_job, out_idx, out_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_job <= 2'd0;
      rd_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_ISSUE;
            busy   <= 1'b1;
            rd_job <= 2'd0;
            rd_idx <= '0;
          end
        end
        ST_ISSUE: begin
          if (rd_en) begin
            if (rd_idx == IDX_LAST) begin
              rd_idx <= '0;
              rd_job <= rd_job + 2'd1;
              if (rd_job == JOB_V) begin
                state <= ST_DRAIN;
              end
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && (out_job == JOB_V) && (out_idx == IDX_LAST)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline matching the one-cycle operand read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      job_q    <= 2'd0;
      idx_q    <= '0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        job_q <= rd_job;
        idx_q <= rd_idx;
      end
    end
  end

  assign use_m = (job_q == JOB_V);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    add_lane_modq #(.Q(Q)) u_lane (
      .a     (rd_a[l*KYBER_R_WIDTH +: KYBER_R_WIDTH]),
      .e     (rd_e[l*SPOLY_W +: SPOLY_W]),
      .m     (rd_m[l*KYBER_R_WIDTH +: KYBER_R_WIDTH]),
      .use_m (use_m),
      .r     (lane_sum[l*KYBER_R_WIDTH +: KYBER_R_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_D; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {job_q, idx_q, lane_sum};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef ADD_SCHED_DEBUG_EN
  assign debug_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if ((state == ST_IDLE) && start) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Without the debug build no observation state is kept.
`endif

endmodule

// File: tb/tb_add_sched.sv
// Randomized self-checking bench for add_sched against an arithmetic reference model of the add stage.
module tb_add_sched;

  localparam int QM    = 3329;
  localparam int NB    = 64;
  localparam int BUDGET = 3000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [1:0]   rd_job;
  logic [3:0]   rd_idx;
  logic [191:0] rd_a;
  logic [47:0]  rd_e;
  logic [191:0] rd_m;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_job;
  logic [3:0]   out_idx;
  logic [191:0] out_data;
`ifdef ADD_SCHED_DEBUG_EN
  logic [2:0]   debug_state;
  logic [15:0]  stall_cnt;
  logic [2:0]   trace [$];
`endif

  add_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_job    (rd_job),
    .rd_idx    (rd_idx),
    .rd_a      (rd_a),
    .rd_e      (rd_e),
    .rd_m      (rd_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_job   (out_job),
    .out_idx   (out_idx),
    .out_data  (out_data)
`ifdef ADD_SCHED_DEBUG_EN
    ,
    .debug_state (debug_state),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference operand store; small coefficients are kept as signed integers.
  int xa  [3][256];
  int e1a [3][256];
  int ya  [256];
  int e2a [256];
  int ma  [256];

  int checks = 0;
  int errors = 0;

  bit           mon_en = 1'b0;
  bit           done_seen;
  bit           stall_prev;
  logic [197:0] prev_fields;
  int           acc_cnt;
  int           issue_cnt;
  int           done_cnt;
  int           model_stall;
  int           first_rd_edge;
  int           first_acc_edge;
  int           done_edge;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rand_small();
    int sel;
    sel = int'($urandom_range(0, 4));
    if (sel <= 2) return sel;
    return (sel == 3) ? -1 : -2;
  endfunction

  function automatic logic [197:0] exp_beat(input int n);
    int job;
    int idx;
    int i;
    int a;
    int e;
    int m;
    int v;
    logic [191:0] d;
    job = n / 16;
    idx = n % 16;
    d = '0;
    for (int l = 0; l < 16; l++) begin
      i = idx * 16 + l;
      a = (job < 3) ? xa[job][i] : ya[i];
      e = (job < 3) ? e1a[job][i] : e2a[i];
      m = (job == 3) ? ma[i] : 0;
      v = ((a + e + m) % QM + QM) % QM;
      d[l*12 +: 12] = 12'(v);
    end
    return {2'(job), 4'(idx), d};
  endfunction

  // Operand memory: captures the request mid-cycle, answers just after the next edge.
  logic pend = 1'b0;
  int   pj = 0;
  int   pi = 0;

  always @(negedge clk) begin
    pend = rd_en;
    pj   = int'(rd_job);
    pi   = int'(rd_idx);
  end

  always @(posedge clk) begin : responder
    int i;
    int a;
    int e;
    int m;
    #1;
    for (int l = 0; l < 16; l++) begin
      i = pi * 16 + l;
      if (pend === 1'b1) begin
        a = (pj < 3) ? xa[pj][i] : ya[i];
        e = (pj < 3) ? e1a[pj][i] : e2a[i];
        m = (pj == 3) ? ma[i] : int'($urandom_range(0, QM - 1));
      end else begin
        a = int'($urandom_range(0, QM - 1));
        e = rand_small();
        m = int'($urandom_range(0, QM - 1));
      end
      rd_a[l*12 +: 12] = 12'(a);
      rd_e[l*3 +: 3]   = 3'((e < 0) ? e + 8 : e);
      rd_m[l*12 +: 12] = 12'(m);
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    int k;
    if (mon_en) begin
      if (stall_prev) begin
        checkOutput("hold_valid", 256'(out_valid), 256'(1));
        checkOutput("hold_fields", 256'({out_job, out_idx, out_data}), 256'(prev_fields));
      end
      if (out_valid && out_ready) begin
        if (first_acc_edge < 0) first_acc_edge = cyc + 1;
        if (acc_cnt < NB) begin
          checkOutput($sformatf("beat%0d", acc_cnt), 256'({out_job, out_idx, out_data}), 256'(exp_beat(acc_cnt)));
        end else begin
          checkOutput("extra_beat", 256'(acc_cnt), 256'(NB - 1));
        end
        acc_cnt++;
      end
      if (rd_en) begin
        if (first_rd_edge < 0) first_rd_edge = cyc + 1;
        k = issue_cnt % NB;
        checkOutput($sformatf("rd_addr%0d", issue_cnt), 256'({rd_job, rd_idx}), 256'({2'(k / 16), 4'(k % 16)}));
        issue_cnt++;
      end
      checkOutput("outstanding_le2", 256'((issue_cnt - acc_cnt) <= 2), 256'(1));
      stall_prev  = out_valid && !out_ready;
      prev_fields = {out_job, out_idx, out_data};
      if (stall_prev) model_stall++;
      if (done) begin
        done_cnt++;
        done_edge = cyc + 1;
        done_seen = 1'b1;
        checkOutput("busy_at_done", 256'(busy), 256'(1));
`ifdef ADD_SCHED_DEBUG_EN
        checkOutput("stall_cnt_at_done", 256'(stall_cnt), 256'(model_stall));
`endif
      end
`ifdef ADD_SCHED_DEBUG_EN
      if (debug_state !== trace[$]) trace.push_back(debug_state);
`endif
    end
  end

  task automatic resetModel();
    done_seen      = 1'b0;
    stall_prev     = 1'b0;
    acc_cnt        = 0;
    issue_cnt      = 0;
    done_cnt       = 0;
    model_stall    = 0;
    first_rd_edge  = -1;
    first_acc_edge = -1;
    done_edge      = -1;
`ifdef ADD_SCHED_DEBUG_EN
    trace = {};
    trace.push_back(debug_state);
`endif
  endtask

  task automatic loadOperands(input int pat);
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 3; k++) begin
        xa[k][i]  = (pat == 0) ? i : int'($urandom_range(0, QM - 1));
        e1a[k][i] = (pat == 0) ? 0 : rand_small();
      end
      case (pat)
        0: begin ya[i] = 0; e2a[i] = 0; ma[i] = 0; end
        1: begin
          ya[i]  = (i % 2 == 0) ? QM - 1 : 0;
          e2a[i] = (i % 2 == 0) ? 2 : -1;
          ma[i]  = (i % 2 == 0) ? QM - 1 : 0;
        end
        default: begin
          ya[i]  = int'($urandom_range(0, QM - 1));
          e2a[i] = rand_small();
          ma[i]  = int'($urandom_range(0, QM - 1));
        end
      endcase
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
    checkOutput({tag, "_done"}, 256'(done), 256'(0));
    checkOutput({tag, "_rd_en"}, 256'(rd_en), 256'(0));
    checkOutput({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    checkOutput({tag, "_rd_addr"}, 256'({rd_job, rd_idx}), 256'(0));
    checkOutput({tag, "_out_fields"}, 256'({out_job, out_idx, out_data}), 256'(0));
  endtask

  // mode 0: ready high; 1: toggling with random stalls; 2: a single 10-cycle stall.
  task automatic applyStimulus(input int mode, input bit restart, input int abort_at);
    int hold;
    bit stall_done;
    int t0;
    hold = 0;
    stall_done = 1'b0;
    resetModel();
    mon_en = 1'b1;
    @(posedge clk); #1;
    out_ready = (mode == 1) ? 1'b0 : 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    for (int c = 0; c < BUDGET && !done_seen; c++) begin
      if (abort_at >= 0 && acc_cnt >= abort_at) begin
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        checkResetState("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else if ($urandom_range(0, 15) == 0) begin
            hold = int'($urandom_range(1, 20));
            out_ready = 1'b0;
          end else begin
            out_ready = ~out_ready;
          end
        end
        default: begin
          if (out_valid && !stall_done) begin
            hold = 10;
            stall_done = 1'b1;
          end
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (restart) start = (c == 20);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("done_seen", 256'(done_seen), 256'(1));
    checkOutput("busy_after_done", 256'(busy), 256'(0));
    checkOutput("done_one_cycle", 256'(done), 256'(0));
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("beat_count", 256'(acc_cnt), 256'(NB));
    checkOutput("issue_count", 256'(issue_cnt), 256'(NB));
    checkOutput("done_count", 256'(done_cnt), 256'(1));
    if (mode == 0) begin
      checkOutput("first_rd_edge", 256'(first_rd_edge - t0), 256'(1));
      checkOutput("first_accept_edge", 256'(first_acc_edge - t0), 256'(3));
      checkOutput("done_edge", 256'(done_edge - t0), 256'(67));
    end
    if (mode == 2) begin
      checkOutput("stall_cycles", 256'(model_stall), 256'(10));
    end
`ifdef ADD_SCHED_DEBUG_EN
    begin
      logic [2:0] exp_tr [5];
      exp_tr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      checkOutput("trace_len", 256'(trace.size()), 256'(5));
      for (int i = 0; i < 5 && i < trace.size(); i++) begin
        checkOutput($sformatf("trace%0d", i), 256'(trace[i]), 256'(exp_tr[i]));
      end
    end
`endif
    mon_en = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    rd_a      = '0;
    rd_e      = '0;
    rd_m      = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    $display("[TB] streaming run with ready held high");
    loadOperands(0);
    applyStimulus(0, 1'b0, -1);

    $display("[TB] modular wrap run");
    loadOperands(1);
    applyStimulus(0, 1'b0, -1);

    $display("[TB] backpressure run");
    loadOperands(2);
    applyStimulus(1, 1'b0, -1);

    $display("[TB] start pulsed while busy");
    loadOperands(2);
    applyStimulus(0, 1'b1, -1);

    $display("[TB] reset mid-run then clean run");
    loadOperands(2);
    applyStimulus(0, 1'b0, 23);
    applyStimulus(0, 1'b0, -1);

    $display("[TB] fixed 10-cycle stall run");
    loadOperands(0);
    applyStimulus(2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
